// File: rtl/oam_dma.sv
// Sprite-attribute DMA engine feeding the PPU's OAM.
// A write to the DMA register latches a source page. LEN bytes are then
// copied from {page, 8'h00} into OAM, one byte per M-cycle tick. Pages
// E0-FF are folded onto the C0-DF work-RAM region they echo.
module oam_dma #(
    parameter int LEN         = 160,
    parameter int SETUP_TICKS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        reg_write,
    input  logic [7:0]  reg_d_wr,
    output logic [7:0]  reg_d_rd,
    output logic [15:0] dma_src_addr,
    input  logic [7:0]  dma_d_in,
    output logic        dma_active,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_d_wr,
    output logic        oam_write
);

    localparam logic [7:0] LAST_IDX   = 8'(LEN - 1);
    localparam logic [7:0] SETUP_LAST = (SETUP_TICKS == 0) ? 8'd0 : 8'(SETUP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  setup_cnt_q, setup_cnt_d;
    logic [7:0]  wr_idx_q, wr_idx_d;
    logic        write_pend_q, write_pend_d;
    logic [15:0] src_addr_q, src_addr_d;
    logic        oam_write_q;
    logic [7:0]  oam_addr_q;
    logic [7:0]  oam_d_wr_q;

    // Echo RAM (E0-FF) aliases C0-DF; everything else reads as written.
    function automatic logic [7:0] eff_page(input logic [7:0] p);
        return (p >= 8'hE0) ? (p & 8'hDF) : p;
    endfunction

    // Next-state logic: register writes, setup pacing, transfer stepping.
    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        idx_d        = idx_q;
        setup_cnt_d  = setup_cnt_q;
        wr_idx_d     = wr_idx_q;
        write_pend_d = 1'b0;
        src_addr_d   = src_addr_q;

        // A tick in XFER always issues its write, even if a restart
        // arrives on the same clock; the restart only cancels the step.
        if (state_q == XFER && tick) begin
            write_pend_d = 1'b1;
            wr_idx_d     = idx_q;
        end

        if (reg_write) begin
            page_d      = reg_d_wr;
            idx_d       = 8'd0;
            setup_cnt_d = 8'd0;
            state_d     = SETUP;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                SETUP: begin
                    if (SETUP_TICKS == 0) begin
                        state_d = XFER;
                    end else if (tick) begin
                        setup_cnt_d = setup_cnt_q + 8'd1;
                        if (setup_cnt_q == SETUP_LAST) begin
                            state_d = XFER;
                        end
                    end
                end
                XFER: begin
                    if (tick) begin
                        idx_d = idx_q + 8'd1;
                        if (idx_q == LAST_IDX) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The final write has left the pending slot once
                    // write_pend_q is clear; its strobe is on the port now.
                    if (!write_pend_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // The read address only moves while transferring, so it is stable
        // between ticks and presented at the edge the byte is fetched.
        if (state_d == XFER) begin
            src_addr_d = {eff_page(page_d), idx_d};
        end
    end

    // Control state register and transfer bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            page_q       <= 8'hFF;
            idx_q        <= 8'd0;
            setup_cnt_q  <= 8'd0;
            wr_idx_q     <= 8'd0;
            write_pend_q <= 1'b0;
            src_addr_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            idx_q        <= idx_d;
            setup_cnt_q  <= setup_cnt_d;
            wr_idx_q     <= wr_idx_d;
            write_pend_q <= write_pend_d;
            src_addr_q   <= src_addr_d;
        end
    end

    // OAM write stage: one clk after the tick, capture the bus read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oam_write_q <= 1'b0;
            oam_addr_q  <= 8'd0;
            oam_d_wr_q  <= 8'd0;
        end else begin
            oam_write_q <= write_pend_q;
            if (write_pend_q) begin
                oam_addr_q <= wr_idx_q;
                oam_d_wr_q <= dma_d_in;
            end
        end
    end

    assign reg_d_rd     = page_q;
    assign dma_src_addr = src_addr_q;
    assign dma_active   = (state_q != IDLE) || write_pend_q;
    assign oam_write    = oam_write_q;
    assign oam_addr     = oam_addr_q;
    assign oam_d_wr     = oam_d_wr_q;

endmodule
